// File: rtl/encoder_proj.sv
// rtl/encoder_proj.sv - Hamming(7,4) encoder: nibble FIFO feeding a one-deep codeword output register.
// Optional build macro ENCODER_PROJ_ERR_INJECT_EN adds single-bit error injection on the output load.
module encoder_proj #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_i,
    input  logic [3:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
`ifdef ENCODER_PROJ_ERR_INJECT_EN
    input  logic                          inj_en,
    input  logic [2:0]                    inj_pos,
`endif
    output logic [6:0]                    io_out,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [7:0]                    sent_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

    logic [3:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic [6:0]    r_cw;
    logic          r_out_valid;
    logic [7:0]    r_sent;

    logic          w_push;
    logic          w_pop;
    logic          w_out_xfer;
    logic          w_empty;
    logic [3:0]    w_head;
    logic [6:0]    w_flip;
    logic [6:0]    w_cw;

    // Bit k-1 of the result is codeword position k: p1 p2 d0 p4 d1 d2 d3.
    function automatic logic [6:0] hamming74(input logic [3:0] d);
        logic p1;
        logic p2;
        logic p4;
        p1 = d[0] ^ d[1] ^ d[3];
        p2 = d[0] ^ d[2] ^ d[3];
        p4 = d[1] ^ d[2] ^ d[3];
        return {d[3], d[2], d[1], p4, d[0], p2, p1};
    endfunction

    // in_ready depends only on registered level, so no path from out_ready.
    assign in_ready   = (r_level != FULL_LEVEL);
    assign w_empty    = (r_level == '0);
    assign w_push     = in_valid && in_ready;
    assign w_out_xfer = r_out_valid && out_ready;
    assign w_pop      = !w_empty && (!r_out_valid || w_out_xfer);
    assign w_head     = r_mem[r_rd_ptr];

    always_comb begin
        w_flip = '0;
`ifdef ENCODER_PROJ_ERR_INJECT_EN
        if (inj_en && (inj_pos != 3'd0)) begin
            w_flip = 7'd1 << (inj_pos - 3'd1);
        end
`endif
        w_cw = hamming74(w_head) ^ w_flip;
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i && w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_cw        <= '0;
            r_out_valid <= 1'b0;
            r_sent      <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
            if (w_pop) begin
                r_cw        <= w_cw;
                r_out_valid <= 1'b1;
            end else if (w_out_xfer) begin
                r_out_valid <= 1'b0;
            end
            if (w_out_xfer) begin
                r_sent <= r_sent + 8'd1;
            end
        end
    end

    assign io_out     = r_cw;
    assign out_valid  = r_out_valid;
    assign fifo_level = r_level;
    assign sent_count = r_sent;

endmodule

// File: doc/encoder_proj.md
ENCODER_PROJ -- requirements
Module: encoder_proj

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, input buffer depth in nibbles (power of two, >= 2).
REQ-002 SHALL have port wb_clk_i  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port wb_rst_i  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_data  input  4  data nibble d3..d0 to encode.
REQ-005 SHALL have port in_valid  input  1  in_data valid.
REQ-006 SHALL have port in_ready  output  1  block can accept a nibble this cycle.
REQ-007 SHALL have port io_out  output  7  Hamming(7,4) codeword; io_out[k-1] = codeword position k.
REQ-008 SHALL have port out_valid  output  1  io_out holds a codeword.
REQ-009 SHALL have port out_ready  input  1  sink accepts io_out this cycle.
REQ-010 SHALL have port fifo_level  output  $clog2(FIFO_DEPTH)+1  nibbles currently buffered.
REQ-011 SHALL have port sent_count  output  8  codewords delivered, wraps at 256.

Function
REQ-012 Input transfer SHALL occur on an edge where in_valid & in_ready; output transfer on an edge where out_valid & out_ready.
REQ-013 in_ready SHALL equal (fifo_level != FIFO_DEPTH); registered-state derived, no combinational path from out_ready.
REQ-014 FIFO SHALL be FIFO_DEPTH deep, wrap-around pointers, strict first-in first-out order.
REQ-015 Encoding: positions 1..7 = p1 p2 d0 p4 d1 d2 d3; p1 = d0^d1^d3, p2 = d0^d2^d3, p4 = d1^d2^d3.
REQ-016 Output stage SHALL be one register; it loads the FIFO head, encoded, on an edge where FIFO non-empty and (out_valid==0 or output transfer occurs).
REQ-017 Latency: nibble accepted at edge N into an empty block SHALL appear with out_valid=1 after edge N+1.
REQ-018 io_out and out_valid SHALL hold stable while out_valid & !out_ready.
REQ-019 Back-to-back: with out_ready held high and FIFO non-empty, one codeword SHALL be delivered every cycle.
REQ-020 out_valid SHALL fall after an output transfer when FIFO is empty at that edge.
REQ-021 Simultaneous push and pop on same edge SHALL leave fifo_level unchanged; push when full SHALL not occur (in_ready low).
REQ-022 sent_count SHALL increment by 1 per output transfer, 255 -> 0 wrap.
REQ-023 in_data while in_ready=0 SHALL be ignored; in_valid SHALL not be required to stay asserted.

Reset
REQ-024 On wb_rst_i high at an edge: FIFO emptied, fifo_level=0, out_valid=0, io_out=7'b0000000, sent_count=0, in_ready=1 after that edge.
REQ-025 Reset mid-operation SHALL discard all buffered and pending codewords; no transfer counted on a reset edge.

Configuration
REQ-026 Macro ENCODER_PROJ_ERR_INJECT_EN, when defined, SHALL add inputs inj_en (1) and inj_pos (3).
REQ-027 With macro: when inj_en=1 and inj_pos in 1..7 on a load edge, codeword position inj_pos SHALL be inverted in the loaded value; inj_pos=0 no flip.
REQ-028 Without macro: ports absent, codewords always exact per REQ-015.

Verification
REQ-029 Reset then push 4'b1011, out_ready=1 -> io_out=7'b1010101, out_valid 1 cycle after accept, sent_count=1.
REQ-030 Push 0x0, 0xF, 0x1 with out_ready=0 -> fifo_level=2, io_out=7'b0000000 held; release out_ready -> 7'b1111111 then 7'b0000111, in order.
REQ-031 out_ready=0, push until in_ready=0 -> FIFO_DEPTH buffered plus 1 in output stage; further in_valid ignored.
REQ-032 Stream 300 nibbles, out_ready=1 -> one per cycle after fill, sent_count=300 mod 256=44.
REQ-033 Assert wb_rst_i with FIFO at 3 -> next cycle out_valid=0, fifo_level=0, sent_count=0, in_ready=1.
REQ-034 With macro, inj_en=1, inj_pos=3, push 4'b0000 -> io_out=7'b0000100; inj_pos=0 -> 7'b0000000.
